xnor_bist_ctrl: RTL and testbench

//   Built-in self-test sequencer for the N-input XNOR gate datapath.
//   - Walks every input vector 0 .. 2^N_IN-1 onto the gate inputs.
//   - Waits a settle window, then samples the gate output.
//   - Compares the sample against the golden ~^vec and counts mismatches.
//   - Sits beside the gate instance and replaces the hand-written stimulus bench with a start/done handshake.

---
 rtl/xnor_bist_if.sv | 50 +++++
 rtl/xnor_bist_ctrl.sv | 132 +++++++++++++
 tb/tb_xnor_bist_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/xnor_bist_if.sv
// Start/done handshake and gate-side bus for the XNOR BIST sequencer.
// The slave side is the sequencer; the master side issues start and
// returns the gate output. With XNOR_BIST_FIRST_FAIL_EN defined, the
// first-failure capture signals are carried as well.
interface xnor_bist_if #(
  parameter int N_IN  = 3,
  parameter int ERR_W = 4
);
  logic             start;
  logic             gate_x;
  logic [N_IN-1:0]  gate_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef XNOR_BIST_FIRST_FAIL_EN
  logic [N_IN-1:0]  fail_vec;
  logic             fail_seen;
`endif

  modport master (
    output start,
    output gate_x,
    input  gate_in,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt
`ifdef XNOR_BIST_FIRST_FAIL_EN
    ,
    input  fail_vec,
    input  fail_seen
`endif
  );

  modport slave (
    input  start,
    input  gate_x,
    output gate_in,
    output busy,
    output done,
    output pass,
    output err_cnt
`ifdef XNOR_BIST_FIRST_FAIL_EN
    ,
    output fail_vec,
    output fail_seen
`endif
  );
endinterface

// File: rtl/xnor_bist_ctrl.sv
// BIST sequencer for an N_IN-input XNOR gate: sweeps every input vector,
// holds each for SETTLE_CYC+1 cycles, samples the gate in the last cycle
// and counts mismatches against ~^vec (saturating).
// Optional first-failure capture: define XNOR_BIST_FIRST_FAIL_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | vector applied, counting settle cycles
// CHECK  | sample gate_x, score, advance or finish
// DONE   | results held until start or rst
module xnor_bist_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  xnor_bist_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N_IN-1:0]  LAST_VEC = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  assign mismatch = (bus.gate_x != ~^vec_q);
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

  // state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // next-state: sweep sequencing and scoring
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SETTLE;
          cnt_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = CHECK;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      CHECK: begin
        if (mismatch) err_d = err_inc;
        if (vec_q == LAST_VEC) begin
          // the last vector stays applied through DONE
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef XNOR_BIST_FIRST_FAIL_EN
  logic [N_IN-1:0] fail_vec_q;
  logic            fail_seen_q;

  // latch the first failing vector of a sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else if (state_q == CHECK && mismatch && !fail_seen_q) begin
      fail_vec_q  <= vec_q;
      fail_seen_q <= 1'b1;
    end
  end

  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_seen = fail_seen_q;
`endif

  assign bus.gate_in = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_xnor_bist_ctrl.sv
// Directed bench for xnor_bist_ctrl: a default instance driven by a
// selectable gate model, plus an ERR_W=3 instance fed by an XOR gate to
// exercise counter saturation.
module tb_xnor_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;
  int   mode    = 0;  // 0 xnor, 1 stuck-at-0, 2 stuck-at-1, 3 xor

  always #5 clk = ~clk;

  xnor_bist_if #(.N_IN(3), .ERR_W(4)) b0 ();
  xnor_bist_if #(.N_IN(3), .ERR_W(3)) b1 ();

  xnor_bist_ctrl #(.N_IN(3), .SETTLE_CYC(2), .ERR_W(4)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave));
  xnor_bist_ctrl #(.N_IN(3), .SETTLE_CYC(2), .ERR_W(3)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave));

  assign b0.gate_x = (mode == 0) ? ~^b0.gate_in :
                     (mode == 1) ? 1'b0 :
                     (mode == 2) ? 1'b1 : ^b0.gate_in;
  assign b1.gate_x = ^b1.gate_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic pulse_start();
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    edge_n = 0;
  endtask

  task automatic wait_done(input string tag);
    while (!b0.done && edge_n < 40) tick();
    chk({tag, "_done_edge"}, edge_n, 24);
  endtask

  initial begin
    rst = 1'b1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    tick(); tick();
    chk("rst_gate_in", b0.gate_in, 0);
    chk("rst_busy",    b0.busy,    0);
    chk("rst_done",    b0.done,    0);
    chk("rst_pass",    b0.pass,    0);
    chk("rst_err",     b0.err_cnt, 0);
`ifdef XNOR_BIST_FIRST_FAIL_EN
    chk("rst_fvec",  b0.fail_vec,  0);
    chk("rst_fseen", b0.fail_seen, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_busy", b0.busy, 0);

    // 1: good gate
    mode = 0;
    pulse_start();
    chk("t1_busy0", b0.busy, 1);
    chk("t1_vec0",  b0.gate_in, 0);
    tick(); tick(); tick();
    chk("t1_vec1",  b0.gate_in, 1);
    wait_done("t1");
    chk("t1_busy", b0.busy, 0);
    chk("t1_pass", b0.pass, 1);
    chk("t1_err",  b0.err_cnt, 0);
    chk("t1_vec",  b0.gate_in, 7);
    tick(); tick();
    chk("t1_hold_done", b0.done, 1);
    chk("t1_hold_vec",  b0.gate_in, 7);

    // 2: stuck-at-0 -> misses on 0,3,5,6
    mode = 1;
    pulse_start();
    chk("t2_done_clr", b0.done, 0);
    wait_done("t2");
    chk("t2_err",  b0.err_cnt, 4);
    chk("t2_pass", b0.pass, 0);
`ifdef XNOR_BIST_FIRST_FAIL_EN
    chk("t2_fvec",  b0.fail_vec,  0);
    chk("t2_fseen", b0.fail_seen, 1);
`endif

    // 3: stuck-at-1 -> misses on 1,2,4,7
    mode = 2;
    pulse_start();
    wait_done("t3");
    chk("t3_err",  b0.err_cnt, 4);
    chk("t3_pass", b0.pass, 0);
`ifdef XNOR_BIST_FIRST_FAIL_EN
    chk("t3_fvec",  b0.fail_vec,  1);
    chk("t3_fseen", b0.fail_seen, 1);
`endif

    // 4: xor gate, all 8 wrong; 4-bit counter reaches 8, 3-bit saturates at 7
    mode = 3;
    b1.start = 1'b1;
    pulse_start();
    b1.start = 1'b0;
    wait_done("t4");
    chk("t4_err8",  b0.err_cnt, 8);
    chk("t4_pass0", b0.pass, 0);
    chk("t4_sat_done", b1.done, 1);
    chk("t4_sat_err",  b1.err_cnt, 7);
    chk("t4_sat_pass", b1.pass, 0);
`ifdef XNOR_BIST_FIRST_FAIL_EN
    chk("t4_fvec", b0.fail_vec, 0);
`endif

    // 5: start mid-sweep is ignored
    mode = 2;
    pulse_start();
    while (edge_n < 10) tick();
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    chk("t5_no_restart_vec", b0.gate_in, 3);
    chk("t5_still_busy",     b0.busy, 1);
    wait_done("t5");
    chk("t5_err", b0.err_cnt, 4);
    pulse_start();
    chk("t5_re_done", b0.done, 0);
    chk("t5_re_err",  b0.err_cnt, 0);
    chk("t5_re_busy", b0.busy, 1);
    chk("t5_re_vec",  b0.gate_in, 0);

    // 6: reset mid-sweep aborts
    while (edge_n < 12) tick();
    chk("t6_pre_vec", b0.gate_in, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vec",  b0.gate_in, 0);
    chk("t6_busy", b0.busy, 0);
    chk("t6_done", b0.done, 0);
    chk("t6_err",  b0.err_cnt, 0);
`ifdef XNOR_BIST_FIRST_FAIL_EN
    chk("t6_fseen", b0.fail_seen, 0);
`endif
    repeat (5) tick();
    chk("t6_idle_busy", b0.busy, 0);
    chk("t6_idle_done", b0.done, 0);

    // rst and start on the same edge: rst wins
    rst = 1'b1;
    b0.start = 1'b1;
    tick();
    rst = 1'b0;
    b0.start = 1'b0;
    chk("rst_vs_start_busy", b0.busy, 0);
    tick();
    chk("rst_vs_start_idle", b0.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
